// File: rtl/nanotrade_pkg.sv
// Shared market-data / circuit-breaker types and helpers.
package nanotrade_pkg;

  localparam int unsigned PRICE_W = 16;
  localparam int unsigned QTY_W   = 8;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned CONF_W  = 8;
  localparam int unsigned CLASS_W = 3;

  typedef enum logic [1:0] {
    MD_TRADE  = 2'b00,
    MD_BID    = 2'b01,
    MD_ASK    = 2'b10,
    MD_CANCEL = 2'b11
  } md_type_e;

  typedef enum logic [2:0] {
    TRIG_NONE  = 3'd0,
    TRIG_FLASH = 3'd3,
    TRIG_IMB   = 3'd4,
    TRIG_STUFF = 3'd5
  } trig_class_e;

  typedef enum logic [1:0] {
    CB_IDLE   = 2'b00,
    CB_ASSERT = 2'b01,
    CB_HOLD   = 2'b10,
    CB_COOL   = 2'b11
  } cb_state_e;

  // Raw per-cycle detections with their confidences
  typedef struct packed {
    logic              flash;
    logic              imb;
    logic              stuff;
    logic [CONF_W-1:0] flash_conf;
    logic [CONF_W-1:0] imb_conf;
    logic [CONF_W-1:0] stuff_conf;
  } det_t;

  function automatic logic [CONF_W-1:0] sat8(input logic [17:0] x);
    return (x > 18'd255) ? 8'hFF : x[7:0];
  endfunction

endpackage

// File: rtl/md_window_stats.sv
// Windowed market-data statistics: price reference, cancel count, bid/ask
// accumulators and the raw FLASH / IMB / STUFF detections they imply.
module md_window_stats
  import nanotrade_pkg::*;
#(
  parameter int unsigned WIN_CYCLES   = 64,
  parameter int unsigned FLASH_DROP   = 16,
  parameter int unsigned STUFF_THRESH = 20,
  parameter int unsigned IMB_MIN      = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               md_valid,
  input  logic [1:0]         md_type,
  input  logic [PRICE_W-1:0] md_price,
  input  logic [QTY_W-1:0]   md_qty,
  output det_t               o_det_c
);

  localparam int unsigned CTR_W = $clog2(WIN_CYCLES);

  logic [CTR_W-1:0]   r_ctr;
  logic [7:0]         r_cancel_cnt;
  logic [ACC_W-1:0]   r_bid_qty;
  logic [ACC_W-1:0]   r_ask_qty;
  logic [PRICE_W-1:0] r_ref_price;
  logic [PRICE_W-1:0] r_last_price;
  logic               r_ref_valid;

  logic               w_wrap, w_trade, w_bid, w_ask, w_cancel;
  logic [7:0]         w_cancel_base, w_cancel_next;
  logic [8:0]         w_cancel_inc;
  logic [ACC_W-1:0]   w_bid_base, w_ask_base, w_bid_next, w_ask_next;
  logic [ACC_W:0]     w_bid_sum, w_ask_sum, w_qty_sum;
  logic [17:0]        w_bid_x3, w_ask_x3;
  logic [PRICE_W:0]   w_price_drop;
  logic [PRICE_W-1:0] w_last_next, w_ref_next;
  logic [CONF_W-1:0]  w_imb_conf_raw;

  assign w_wrap   = (r_ctr == CTR_W'(WIN_CYCLES - 1));
  assign w_trade  = md_valid && (md_type == MD_TRADE);
  assign w_bid    = md_valid && (md_type == MD_BID);
  assign w_ask    = md_valid && (md_type == MD_ASK);
  assign w_cancel = md_valid && (md_type == MD_CANCEL);

  // Next-window state: the wrap-cycle event already belongs to the new window
  always_comb begin
    w_cancel_base = w_wrap ? 8'd0 : r_cancel_cnt;
    w_cancel_inc  = 9'(w_cancel_base) + 9'd1;
    w_cancel_next = w_cancel_base;
    if (w_cancel) w_cancel_next = w_cancel_inc[8] ? 8'hFF : w_cancel_inc[7:0];

    w_bid_base = w_wrap ? '0 : r_bid_qty;
    w_ask_base = w_wrap ? '0 : r_ask_qty;
    w_bid_sum  = (ACC_W+1)'(w_bid_base) + (ACC_W+1)'(md_qty);
    w_ask_sum  = (ACC_W+1)'(w_ask_base) + (ACC_W+1)'(md_qty);
    w_bid_next = w_bid_base;
    w_ask_next = w_ask_base;
    if (w_bid) w_bid_next = w_bid_sum[ACC_W] ? '1 : w_bid_sum[ACC_W-1:0];
    if (w_ask) w_ask_next = w_ask_sum[ACC_W] ? '1 : w_ask_sum[ACC_W-1:0];

    w_last_next = w_trade ? md_price : r_last_price;
    w_ref_next  = r_ref_price;
    if (w_wrap)                        w_ref_next = w_last_next;
    else if (w_trade && !r_ref_valid)  w_ref_next = md_price;
  end

  // Raw detections, evaluated against pre-update state
  always_comb begin
    w_price_drop   = (PRICE_W+1)'(md_price) + (PRICE_W+1)'(FLASH_DROP);
    w_qty_sum      = (ACC_W+1)'(r_bid_qty) + (ACC_W+1)'(r_ask_qty);
    w_bid_x3       = 18'({r_bid_qty, 1'b0}) + 18'(r_bid_qty);
    w_ask_x3       = 18'({r_ask_qty, 1'b0}) + 18'(r_ask_qty);
    w_imb_conf_raw = sat8(18'(w_qty_sum >> 2));

    o_det_c            = '0;
    o_det_c.flash      = w_trade && r_ref_valid &&
                         (w_price_drop <= (PRICE_W+1)'(r_ref_price));
    o_det_c.flash_conf = sat8({r_ref_price - md_price, 2'b00});
    o_det_c.stuff      = w_cancel && (w_cancel_inc >= 9'(STUFF_THRESH));
    o_det_c.stuff_conf = sat8(18'({w_cancel_inc, 1'b0}));
    o_det_c.imb        = w_wrap && (18'(w_qty_sum) >= 18'(IMB_MIN)) &&
                         ((18'(r_bid_qty) > w_ask_x3) || (18'(r_ask_qty) > w_bid_x3));
    o_det_c.imb_conf   = (w_imb_conf_raw == '0) ? 8'd1 : w_imb_conf_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr        <= '0;
      r_cancel_cnt <= '0;
      r_bid_qty    <= '0;
      r_ask_qty    <= '0;
      r_ref_price  <= '0;
      r_last_price <= '0;
      r_ref_valid  <= 1'b0;
    end else begin
      r_ctr        <= w_wrap ? '0 : r_ctr + CTR_W'(1);
      r_cancel_cnt <= w_cancel_next;
      r_bid_qty    <= w_bid_next;
      r_ask_qty    <= w_ask_next;
      r_ref_price  <= w_ref_next;
      r_last_price <= w_last_next;
      r_ref_valid  <= r_ref_valid | w_trade;
    end
  end

endmodule

// File: rtl/anomaly_trigger_gen.sv
// Anomaly detector front end for the circuit breaker: arbitrates raw
// detections and drives the level-held trig_valid/class/conf handshake.
module anomaly_trigger_gen
  import nanotrade_pkg::*;
#(
  parameter int unsigned WIN_CYCLES   = 64,
  parameter int unsigned FLASH_DROP   = 16,
  parameter int unsigned STUFF_THRESH = 20,
  parameter int unsigned IMB_MIN      = 64,
  parameter int unsigned ACK_TIMEOUT  = 8,
  parameter int unsigned COOL_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               md_valid,
  input  logic [1:0]         md_type,
  input  logic [PRICE_W-1:0] md_price,
  input  logic [QTY_W-1:0]   md_qty,
  input  logic               cb_active,
  output logic               trig_valid,
  output logic [CLASS_W-1:0] trig_class,
  output logic [CONF_W-1:0]  trig_conf,
  output logic [1:0]         det_state,
  output logic [7:0]         drop_cnt
);

  localparam int unsigned TMO_W  = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned COOL_W = (COOL_CYCLES > 2) ? $clog2(COOL_CYCLES) : 1;

  cb_state_e          r_state;
  logic               r_trig_valid;
  logic [CLASS_W-1:0] r_trig_class;
  logic [CONF_W-1:0]  r_trig_conf;
  logic [7:0]         r_drop_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [COOL_W-1:0]  r_cool_cnt;

  det_t               w_det;
  logic [1:0]         w_num;
  logic [CLASS_W-1:0] w_win_class;
  logic [CONF_W-1:0]  w_win_conf;
  logic               w_ack_tmo;
  logic [2:0]         w_drop_inc;
  logic [8:0]         w_drop_sum;

  md_window_stats #(
    .WIN_CYCLES   (WIN_CYCLES),
    .FLASH_DROP   (FLASH_DROP),
    .STUFF_THRESH (STUFF_THRESH),
    .IMB_MIN      (IMB_MIN)
  ) u_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_valid (md_valid),
    .md_type  (md_type),
    .md_price (md_price),
    .md_qty   (md_qty),
    .o_det_c  (w_det)
  );

  // Priority FLASH > IMB > STUFF; every detection not issued is counted as dropped
  always_comb begin
    w_num       = 2'(w_det.flash) + 2'(w_det.imb) + 2'(w_det.stuff);
    w_win_class = TRIG_STUFF;
    w_win_conf  = w_det.stuff_conf;
    if (w_det.flash) begin
      w_win_class = TRIG_FLASH;
      w_win_conf  = w_det.flash_conf;
    end else if (w_det.imb) begin
      w_win_class = TRIG_IMB;
      w_win_conf  = w_det.imb_conf;
    end
    w_ack_tmo = (r_state == CB_ASSERT) && !cb_active &&
                (r_tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
    if (r_state == CB_IDLE) w_drop_inc = (w_num == 2'd0) ? 3'd0 : 3'(w_num) - 3'd1;
    else                    w_drop_inc = 3'(w_num);
    w_drop_inc = w_drop_inc + 3'(w_ack_tmo);
    w_drop_sum = 9'(r_drop_cnt) + 9'(w_drop_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CB_IDLE;
      r_trig_valid <= 1'b0;
      r_trig_class <= '0;
      r_trig_conf  <= '0;
      r_drop_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_cool_cnt   <= '0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      case (r_state)
        CB_IDLE: begin
          if (w_num != 2'd0) begin
            r_state      <= CB_ASSERT;
            r_trig_valid <= 1'b1;
            r_trig_class <= w_win_class;
            r_trig_conf  <= w_win_conf;
            r_tmo_cnt    <= '0;
          end
        end
        CB_ASSERT: begin
          if (cb_active) begin
            r_state      <= CB_HOLD;
            r_trig_valid <= 1'b0;
            r_trig_class <= '0;
            r_trig_conf  <= '0;
          end else if (w_ack_tmo) begin
            r_state      <= CB_COOL;
            r_trig_valid <= 1'b0;
            r_trig_class <= '0;
            r_trig_conf  <= '0;
            r_cool_cnt   <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        CB_HOLD: begin
          if (!cb_active) begin
            r_state    <= CB_COOL;
            r_cool_cnt <= '0;
          end
        end
        CB_COOL: begin
          if (r_cool_cnt == COOL_W'(COOL_CYCLES - 1)) r_state <= CB_IDLE;
          else                                        r_cool_cnt <= r_cool_cnt + COOL_W'(1);
        end
        default: r_state <= CB_IDLE;
      endcase
    end
  end

  assign trig_valid = r_trig_valid;
  assign trig_class = r_trig_class;
  assign trig_conf  = r_trig_conf;
  assign det_state  = r_state;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_anomaly_trigger_gen.sv
// Self-checking bench for anomaly_trigger_gen: directed scenarios with fixed
// expectations plus a randomized run against an event-level reference model.
module tb_anomaly_trigger_gen;

  localparam int WIN = 64, FD = 16, ST = 20, IMBM = 64, ACK = 8, COOL = 16;

  logic        clk, rst_n, md_valid, cb_active;
  logic [1:0]  md_type;
  logic [15:0] md_price;
  logic [7:0]  md_qty;
  logic        trig_valid;
  logic [2:0]  trig_class;
  logic [7:0]  trig_conf;
  logic [1:0]  det_state;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  anomaly_trigger_gen #(
    .WIN_CYCLES(WIN), .FLASH_DROP(FD), .STUFF_THRESH(ST),
    .IMB_MIN(IMBM), .ACK_TIMEOUT(ACK), .COOL_CYCLES(COOL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .md_valid(md_valid), .md_type(md_type),
    .md_price(md_price), .md_qty(md_qty), .cb_active(cb_active),
    .trig_valid(trig_valid), .trig_class(trig_class), .trig_conf(trig_conf),
    .det_state(det_state), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: window bookkeeping and episode phase (0 idle,1 assert,2 hold,3 cool)
  int m_cyc, m_cancel, m_bid, m_ask, m_ref, m_last;
  bit m_refv, m_tv;
  int m_ph, m_cls, m_conf, m_drop, m_in_assert, m_in_cool;

  function automatic int sat(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_cancel = 0; m_bid = 0; m_ask = 0; m_ref = 0; m_last = 0;
    m_refv = 0; m_tv = 0; m_ph = 0; m_cls = 0; m_conf = 0; m_drop = 0;
    m_in_assert = 0; m_in_cool = 0;
  endtask

  task automatic model_step();
    bit wrap, fl, im, sf;
    int fc, ic, sc, n, p, q, t;
    wrap = (m_cyc % WIN) == WIN - 1;
    p = md_price; q = md_qty; t = md_type;
    fl = 0; im = 0; sf = 0; fc = 0; ic = 0; sc = 0;
    if (md_valid && t == 0 && m_refv && p + FD <= m_ref) begin
      fl = 1; fc = sat((m_ref - p) * 4, 255);
    end
    if (wrap && m_bid + m_ask >= IMBM && (m_bid > 3 * m_ask || m_ask > 3 * m_bid)) begin
      im = 1; ic = sat((m_bid + m_ask) / 4, 255);
      if (ic < 1) ic = 1;
    end
    if (wrap) begin m_bid = 0; m_ask = 0; m_cancel = 0; end
    if (md_valid && t == 3) begin
      if (m_cancel + 1 >= ST) begin sf = 1; sc = sat((m_cancel + 1) * 2, 255); end
      m_cancel = sat(m_cancel + 1, 255);
    end
    if (md_valid && t == 1) m_bid = sat(m_bid + q, 65535);
    if (md_valid && t == 2) m_ask = sat(m_ask + q, 65535);
    if (md_valid && t == 0) begin
      if (!m_refv) m_ref = p;
      m_refv = 1; m_last = p;
    end
    if (wrap) m_ref = m_last;
    m_cyc++;
    n = fl + im + sf;
    if (m_ph == 0) begin
      if (n > 0) begin
        m_ph = 1; m_tv = 1; m_in_assert = 1;
        m_cls  = fl ? 3 : (im ? 4 : 5);
        m_conf = fl ? fc : (im ? ic : sc);
        m_drop = sat(m_drop + n - 1, 255);
      end
    end else begin
      m_drop = sat(m_drop + n, 255);
      if (m_ph == 1) begin
        if (cb_active) begin m_ph = 2; m_tv = 0; m_cls = 0; m_conf = 0; end
        else if (m_in_assert == ACK) begin
          m_ph = 3; m_tv = 0; m_cls = 0; m_conf = 0; m_in_cool = 0;
          m_drop = sat(m_drop + 1, 255);
        end else m_in_assert++;
      end else if (m_ph == 2) begin
        if (!cb_active) begin m_ph = 3; m_in_cool = 0; end
      end else begin
        m_in_cool++;
        if (m_in_cool == COOL) m_ph = 0;
      end
    end
  endtask

  task automatic tick(input bit v, input int t, input int p, input int q, input bit cb);
    md_valid = v; md_type = 2'(t); md_price = 16'(p); md_qty = 8'(q); cb_active = cb;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; md_valid = 0; md_type = 0; md_price = 0; md_qty = 0; cb_active = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; md_valid = 0; md_type = 0; md_price = 0; md_qty = 0; cb_active = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({trig_valid, trig_class, trig_conf} !== 12'd0) begin
      errors++; $display("FAIL reset_trig got=%b/%0d/%0d exp=0/0/0", trig_valid, trig_class, trig_conf);
    end
    checks++;
    if ({det_state, drop_cnt} !== 10'd0) begin
      errors++; $display("FAIL reset_state got=%0d/%0d exp=0/0", det_state, drop_cnt);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_flash();
    do_reset();
    tick(1, 0, 1000, 0, 0);
    checks++;
    if (trig_valid !== 1'b0) begin errors++; $display("FAIL flash_first_trade tv=%b exp=0", trig_valid); end
    tick(1, 0, 980, 0, 0);
    checks++;
    if ({trig_valid, trig_class, trig_conf, det_state} !== {1'b1, 3'd3, 8'd80, 2'd1}) begin
      errors++; $display("FAIL flash_issue got tv=%b cls=%0d conf=%0d st=%0d exp 1/3/80/1",
                         trig_valid, trig_class, trig_conf, det_state);
    end
    tick(0, 0, 0, 0, 0);
    checks++;
    if (trig_valid !== 1'b1) begin errors++; $display("FAIL flash_hold2 tv=%b exp=1", trig_valid); end
    tick(0, 0, 0, 0, 1);
    checks++;
    if ({trig_valid, trig_class, det_state} !== {1'b0, 3'd0, 2'd2}) begin
      errors++; $display("FAIL flash_ack got tv=%b cls=%0d st=%0d exp 0/0/2", trig_valid, trig_class, det_state);
    end
    repeat (3) tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    checks++;
    if (det_state !== 2'd3) begin errors++; $display("FAIL flash_cool_entry st=%0d exp=3", det_state); end
    repeat (COOL - 1) tick(0, 0, 0, 0, 0);
    checks++;
    if (det_state !== 2'd3) begin errors++; $display("FAIL flash_cool_len st=%0d exp=3", det_state); end
    tick(0, 0, 0, 0, 0);
    checks++;
    if ({det_state, drop_cnt} !== {2'd0, 8'd0}) begin
      errors++; $display("FAIL flash_idle got st=%0d drop=%0d exp 0/0", det_state, drop_cnt);
    end
  endtask

  task automatic test_stuff();
    bit seen;
    do_reset();
    seen = 0;
    repeat (ST - 1) begin tick(1, 3, 0, 0, 0); if (trig_valid) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL stuff_early tv=1 exp=0 before cancel %0d", ST); end
    tick(1, 3, 0, 0, 0);
    checks++;
    if ({trig_valid, trig_class, trig_conf} !== {1'b1, 3'd5, 8'd40}) begin
      errors++; $display("FAIL stuff_issue got tv=%b cls=%0d conf=%0d exp 1/5/40", trig_valid, trig_class, trig_conf);
    end
    do_reset();
    seen = 0;
    repeat (WIN - ST) tick(0, 0, 0, 0, 0);
    repeat (ST - 1) begin tick(1, 3, 0, 0, 0); if (trig_valid) seen = 1; end
    tick(0, 0, 0, 0, 0); if (trig_valid) seen = 1;
    tick(1, 3, 0, 0, 0); if (trig_valid) seen = 1;
    checks++;
    if (seen || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL stuff_wrap_clear seen=%b drop=%0d exp 0/0", seen, drop_cnt);
    end
  endtask

  task automatic test_imb();
    bit seen;
    do_reset();
    tick(1, 1, 0, 100, 0); tick(1, 1, 0, 100, 0); tick(1, 2, 0, 40, 0);
    repeat (WIN - 4) tick(0, 0, 0, 0, 0);
    checks++;
    if (trig_valid !== 1'b0) begin errors++; $display("FAIL imb_early tv=%b exp=0", trig_valid); end
    tick(0, 0, 0, 0, 0);
    checks++;
    if ({trig_valid, trig_class, trig_conf} !== {1'b1, 3'd4, 8'd60}) begin
      errors++; $display("FAIL imb_issue got tv=%b cls=%0d conf=%0d exp 1/4/60", trig_valid, trig_class, trig_conf);
    end
    do_reset();
    seen = 0;
    tick(1, 1, 0, 120, 0); tick(1, 2, 0, 40, 0);
    repeat (WIN) begin tick(0, 0, 0, 0, 0); if (trig_valid) seen = 1; end
    checks++;
    if (seen || det_state !== 2'd0) begin
      errors++; $display("FAIL imb_ratio_edge seen=%b st=%0d exp 0/0", seen, det_state);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    tick(1, 0, 1000, 0, 0);
    tick(1, 0, 980, 0, 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!trig_valid) break;
      n++;
      tick(0, 0, 0, 0, 0);
    end
    checks++;
    if (n !== ACK) begin errors++; $display("FAIL timeout_len got=%0d exp=%0d", n, ACK); end
    checks++;
    if ({det_state, drop_cnt} !== {2'd3, 8'd1}) begin
      errors++; $display("FAIL timeout_drop got st=%0d drop=%0d exp 3/1", det_state, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(1, 1, 0, 200, 0); tick(1, 2, 0, 40, 0); tick(1, 0, 1000, 0, 0);
    repeat (WIN - 4) tick(0, 0, 0, 0, 0);
    tick(1, 0, 980, 0, 0);
    checks++;
    if ({trig_valid, trig_class, trig_conf, drop_cnt} !== {1'b1, 3'd3, 8'd80, 8'd1}) begin
      errors++; $display("FAIL wrap_priority got tv=%b cls=%0d conf=%0d drop=%0d exp 1/3/80/1",
                         trig_valid, trig_class, trig_conf, drop_cnt);
    end
    tick(0, 0, 0, 0, 1);
    checks++;
    if ({trig_valid, det_state} !== {1'b0, 2'd2}) begin
      errors++; $display("FAIL wrap_hold got tv=%b st=%0d exp 0/2", trig_valid, det_state);
    end
    tick(1, 0, 900, 0, 1);
    checks++;
    if ({trig_valid, det_state, drop_cnt} !== {1'b0, 2'd2, 8'd2}) begin
      errors++; $display("FAIL hold_discard got tv=%b st=%0d drop=%0d exp 0/2/2", trig_valid, det_state, drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    tick(1, 1, 0, 200, 0); tick(1, 2, 0, 40, 0);
    tick(1, 0, 1000, 0, 0); tick(1, 0, 980, 0, 0);
    checks++;
    if (trig_valid !== 1'b1) begin errors++; $display("FAIL rstmid_setup tv=%b exp=1", trig_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({trig_valid, trig_class, trig_conf, det_state, drop_cnt} !== 22'd0) begin
      errors++; $display("FAIL rstmid_async got tv=%b cls=%0d conf=%0d st=%0d drop=%0d exp all 0",
                         trig_valid, trig_class, trig_conf, det_state, drop_cnt);
    end
    do_reset();
    seen = 0;
    repeat (WIN) begin tick(0, 0, 0, 0, 0); if (trig_valid) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL rstmid_stale tv=1 exp=0 without new evidence"); end
    tick(1, 0, 1000, 0, 0);
    tick(1, 0, 980, 0, 0);
    checks++;
    if ({trig_valid, trig_class} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL rstmid_new got tv=%b cls=%0d exp 1/3", trig_valid, trig_class);
    end
  endtask

  task automatic test_random();
    int mode, r, t, p, q;
    bit cb, v;
    do_reset();
    cb = 0; mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % WIN == 0) mode = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      v = ($urandom_range(0, 9) != 0);
      case (mode)
        0:       t = (r < 5) ? 3 : r % 3;
        1:       t = (r < 6) ? 1 : ((r < 8) ? 0 : 3);
        default: t = r % 4;
      endcase
      p = 1000 + $urandom_range(0, 30) - 15;
      if ($urandom_range(0, 15) == 0) p = p - 40;
      q = $urandom_range(0, 255);
      if (trig_valid && $urandom_range(0, 2) == 0) cb = 1;
      else if (cb && $urandom_range(0, 5) == 0) cb = 0;
      else if (!cb && $urandom_range(0, 39) == 0) cb = 1;
      tick(v, t, p, q, cb);
      checks++;
      if ({trig_valid, trig_class, trig_conf, det_state, drop_cnt} !==
          {m_tv, 3'(m_cls), 8'(m_conf), 2'(m_ph), 8'(m_drop)}) begin
        errors++;
        $display("FAIL random_cyc%0d got tv=%b cls=%0d conf=%0d st=%0d drop=%0d exp %b/%0d/%0d/%0d/%0d",
                 i, trig_valid, trig_class, trig_conf, det_state, drop_cnt,
                 m_tv, m_cls, m_conf, m_ph, m_drop);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; md_valid = 0; md_type = 0; md_price = 0; md_qty = 0; cb_active = 0;
    model_reset();
    test_reset();
    test_flash();
    test_stuff();
    test_imb();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/anomaly_trigger_gen.md
# anomaly_trigger_gen

Market-data anomaly detector and trigger initiator for the circuit breaker. Watches the normalized market-data event stream, detects flash crashes, order-book imbalance and quote stuffing over a fixed observation window, and drives the breaker's level-held trigger interface (trig_valid/trig_class/trig_conf) until the breaker acknowledges by raising cb_active. Sits between the feed decoder and circuit_breaker.

## Interface
- WIN_CYCLES, 64: observation window length in cycles (power of two not required, ≥4)
- FLASH_DROP, 16: price drop in ticks below window reference that flags FLASH
- STUFF_THRESH, 20: cancels per window that flag STUFF
- IMB_MIN, 64: minimum bid+ask qty in window before IMB is evaluated
- ACK_TIMEOUT, 8: cycles trig_valid is held without cb_active before abandoning
- COOL_CYCLES, 16: quiet cycles after an episode before a new trigger may issue
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- md_valid  in  1  one market-data event this cycle
- md_type  in  2  00 trade, 01 bid add, 10 ask add, 11 cancel
- md_price  in  16  trade price in ticks (used for trade only)
- md_qty  in  8  order qty (used for bid/ask add)
- cb_active  in  1  breaker active flag (acknowledge)
- trig_valid  out  1  trigger request, level held
- trig_class  out  3  3 FLASH, 4 IMB, 5 STUFF; 0 when trig_valid=0
- trig_conf  out  8  confidence, ≥1 whenever trig_valid=1
- det_state  out  2  FSM state encoding
- drop_cnt  out  8  saturating count of discarded/abandoned detections

## Operation
- Window counter 0..WIN_CYCLES-1, free-running. At wrap edge (ctr==WIN_CYCLES-1): evaluate IMB on accumulators excluding the current event, then clear cancel_cnt, bid_qty, ask_qty; current-cycle event counts toward the new window; ref_price <= last trade price, ref_valid <= any trade ever seen.
- Flash: on trade, if !ref_valid set ref_price=md_price. If ref_valid and md_price+FLASH_DROP ≤ ref_price (17-bit unsigned compare): detect FLASH, conf = sat8((ref_price-md_price)<<2). Every trade updates last trade price.
- Stuffing: cancel_cnt 8-bit saturating; on cancel, if cancel_cnt+1 ≥ STUFF_THRESH detect STUFF, conf = sat8((cancel_cnt+1)<<1).
- Imbalance: bid_qty/ask_qty 16-bit saturating accumulators. At wrap, if bid+ask ≥ IMB_MIN and (bid > 3·ask or ask > 3·bid; 18-bit arithmetic): detect IMB, conf = sat8((bid+ask)>>2), floored at 1.
- Same-cycle detections: priority FLASH > IMB > STUFF; losers increment drop_cnt once.
- FSM IDLE(00): on detection load class/conf, go ASSERT. ASSERT(01): trig_valid=1, class/conf frozen; cb_active=1 → HOLD; ACK_TIMEOUT cycles without it → COOL, drop_cnt+1. HOLD(10): trig_valid=0; cb_active=0 → COOL. COOL(11): count COOL_CYCLES then IDLE.
- Detections in any state other than IDLE are discarded, drop_cnt+1 each. Detection logic keeps running in all states.
- cb_active already 1 on entry to ASSERT counts as acknowledge (breaker engaged by another source).

## Timing
- Reset values: trig_valid 0, trig_class 0, trig_conf 0, det_state IDLE, drop_cnt 0; all counters/accumulators 0, ref_valid 0.
- Event sampled at edge k → trig_valid high after edge k (1-cycle latency), class/conf valid same cycle.
- Breaker raises cb_active one edge after sampling trig_valid; trig_valid drops the edge cb_active is sampled high (trig_valid high exactly 2 cycles in a normal handshake).
- Timeout: trig_valid high exactly ACK_TIMEOUT cycles, then COOL.
- Reset mid-episode: outputs to reset values immediately (async), window restarts at 0.

## Structure
- Shared package nanotrade_pkg: trigger class codes, cb_state codes, md_type codes, sat8 function.
- Sub-module md_window_stats: window counter, accumulators, ref/last price, raw detect flags + conf; FSM and arbitration in top.

## Test plan
- Trades 1000 then 980 in one window → trig_valid with class 3, conf 80; cb_active raised next cycle → trig_valid drops, HOLD until cb_active=0, then COOL 16 cycles, IDLE.
- 20 cancels in one window → class 5, conf 40 on the 20th cancel; 19 cancels then wrap → no trigger.
- Window with bid adds totalling 200, ask 40 → class 4 at wrap edge, conf 60; bid 120/ask 40 → no trigger.
- Trigger with cb_active held 0 → trig_valid high exactly 8 cycles, drop_cnt=1, COOL.
- Flash trade on the wrap cycle of an imbalanced window → class 3 issued, drop_cnt+1; second flash during HOLD → discarded, drop_cnt+1.
- Assert rst_n low during ASSERT → trig_valid 0 same cycle, accumulators cleared, no trigger until new evidence.
